// File: rtl/csk_add_pkg.sv
// Shared types and constants for the shared carry-skip adder arbiter.
package csk_add_pkg;

    localparam int CSK_W    = 15;
    localparam int CSK_NREQ = 4;
    localparam int CSK_IDW  = $clog2(CSK_NREQ);

    typedef logic [CSK_W-1:0]   operand_t;
    typedef logic [CSK_W:0]     sum_t;
    typedef logic [CSK_IDW-1:0] req_id_t;

endpackage

// File: rtl/csk_add_arbiter_if.sv
// Request/response bus between the client blocks and the shared adder.
interface csk_add_arbiter_if
    import csk_add_pkg::*;
#(
    parameter int NREQ = CSK_NREQ,
    parameter int W    = CSK_W,
    parameter int IDW  = $clog2(NREQ)
);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [NREQ-1:0]   req_chain;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W:0]        rsp_sum;
    logic [IDW-1:0]    rsp_id;
    logic              busy;

    // Client side: drives requests, consumes results.
    modport master (
        output req_valid, req_x, req_y, req_chain, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_id, busy
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_x, req_y, req_chain, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_id, busy
    );

endinterface

// File: rtl/csk_add15.sv
// Combinational W-bit carry-skip adder with carry-in, built from 2-bit
// ripple blocks whose carry-out may bypass the block when every bit
// propagates. An odd W leaves a final 1-bit block.
module csk_add15
    import csk_add_pkg::*;
#(
    parameter int W = CSK_W
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W:0]   sum
);

    localparam int NB = (W + 1) / 2;

    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W-1:0] bit_cin;
    logic [W-1:0] bit_cout;
    logic [NB-1:0] blk_p;
    logic [NB:0]   blk_cin;

    assign p = x ^ y;
    assign g = x & y;
    assign blk_cin[0] = cin;

    // Bit-level ripple inside each block; the first bit of a block takes
    // the (possibly skipped) block carry-in.
    for (genvar i = 0; i < W; i++) begin : g_bit
        if (i % 2 == 0) begin : g_first
            assign bit_cin[i] = blk_cin[i/2];
        end else begin : g_next
            assign bit_cin[i] = bit_cout[i-1];
        end
        assign sum[i]      = p[i] ^ bit_cin[i];
        assign bit_cout[i] = g[i] | (p[i] & bit_cin[i]);
    end

    // Block carry: ripple result or the skip path when all bits propagate.
    for (genvar b = 0; b < NB; b++) begin : g_blk
        localparam int LO = 2 * b;
        localparam int HI = (2 * b + 1 < W) ? 2 * b + 1 : W - 1;
        assign blk_p[b]     = &p[HI:LO];
        assign blk_cin[b+1] = bit_cout[HI] | (blk_p[b] & blk_cin[b]);
    end

    assign sum[W] = blk_cin[NB];

endmodule

// File: rtl/csk_add_arbiter.sv
// Round-robin arbiter sharing one carry-skip adder among NREQ clients,
// with per-client saved carries for multi-word chains and a single
// registered result stage using a valid/ready handshake.
module csk_add_arbiter
    import csk_add_pkg::*;
#(
    parameter int NREQ = CSK_NREQ,
    parameter int W    = CSK_W,
    parameter int IDW  = $clog2(NREQ)
) (
    input logic            clk,
    input logic            rst_n,
    csk_add_arbiter_if.slave bus
);

    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant;
    logic [IDW-1:0]  next_ptr;
    logic            found;
    logic            can_load;
    logic            accept;
    logic [NREQ-1:0] carry;
    logic [W-1:0]    x_g;
    logic [W-1:0]    y_g;
    logic            cin_g;
    logic [W:0]      sum_g;

    assign can_load = !bus.rsp_valid || bus.rsp_ready;
    assign accept   = found && can_load;
    assign bus.busy = bus.rsp_valid || (|bus.req_valid);

    // Pick the first valid requester starting at rr_ptr, wrapping around.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                grant = IDW'(idx);
            end
        end
    end

    // Only the granted requester sees ready, and only when the result
    // register can take a new value this cycle.
    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[grant] = 1'b1;
        end
    end

    // Steer the granted operands and carry-in into the shared adder.
    always_comb begin
        x_g   = bus.req_x[int'(grant)*W +: W];
        y_g   = bus.req_y[int'(grant)*W +: W];
        cin_g = bus.req_chain[grant] & carry[grant];
    end

    assign next_ptr = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;

    csk_add15 #(
        .W (W)
    ) u_adder (
        .x   (x_g),
        .y   (y_g),
        .cin (cin_g),
        .sum (sum_g)
    );

    // Result register, saved carries and round-robin pointer; a new accept
    // reloads the register even while the old result is being consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_sum   <= '0;
            bus.rsp_id    <= '0;
            rr_ptr        <= '0;
            carry         <= '0;
        end else if (accept) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_sum   <= sum_g;
            bus.rsp_id    <= grant;
            rr_ptr        <= next_ptr;
            carry[grant]  <= sum_g[W];
        end else if (bus.rsp_valid && bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_csk_add_arbiter.sv
// Self-checking bench for csk_add_arbiter: a reference model predicts
// grants and sums, pushing expected results into a scoreboard queue that
// is popped when the result register updates.
module tb_csk_add_arbiter;
    import csk_add_pkg::*;

    localparam int NREQ = CSK_NREQ;
    localparam int W    = CSK_W;

    typedef struct {
        sum_t    sum;
        req_id_t id;
    } exp_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    logic [NREQ-1:0] m_carry;
    int              m_rr;
    bit              m_valid;
    sum_t            cur_sum;
    req_id_t         cur_id;
    exp_t            sb[$];

    csk_add_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    csk_add_arbiter #(
        .NREQ (NREQ),
        .W    (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_carry = '0;
        m_rr    = 0;
        m_valid = 1'b0;
        cur_sum = '0;
        cur_id  = '0;
        sb.delete();
    endtask

    task automatic set_req(input int i, input logic v, input operand_t x,
                           input operand_t y, input logic ch);
        bus.req_valid[i]       = v;
        bus.req_x[i*W +: W]    = x;
        bus.req_y[i*W +: W]    = y;
        bus.req_chain[i]       = ch;
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.req_chain = '0;
    endtask

    // One clock: check ready/busy mid-cycle, predict the accept, then check
    // the result register just after the rising edge.
    task automatic cycle(output int acc_id);
        int              g;
        bit              acc;
        bit              ready_s;
        logic [NREQ-1:0] exp_ready;
        operand_t        x;
        operand_t        y;
        logic            cin;
        sum_t            s;
        exp_t            e;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && bus.req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
        end
        acc       = (g >= 0) && (!m_valid || bus.rsp_ready);
        exp_ready = '0;
        if (acc) exp_ready[g] = 1'b1;
        vectors++;
        if (bus.req_ready !== exp_ready) begin
            miscompares++;
            $display("[TB] FAIL req_ready: got %b expected %b", bus.req_ready, exp_ready);
        end
        vectors++;
        if (bus.busy !== (m_valid || (|bus.req_valid))) begin
            miscompares++;
            $display("[TB] FAIL busy: got %b expected %b", bus.busy, m_valid || (|bus.req_valid));
        end
        ready_s = bus.rsp_ready;
        acc_id  = -1;
        if (acc) begin
            x   = bus.req_x[g*W +: W];
            y   = bus.req_y[g*W +: W];
            cin = bus.req_chain[g] & m_carry[g];
            s   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
            e.sum = s;
            e.id  = req_id_t'(g);
            sb.push_back(e);
            m_carry[g] = s[W];
            m_rr       = (g + 1) % NREQ;
            acc_id     = g;
        end
        @(posedge clk);
        #1;
        if (acc) begin
            e       = sb.pop_front();
            cur_sum = e.sum;
            cur_id  = e.id;
            m_valid = 1'b1;
        end else if (m_valid && ready_s) begin
            m_valid = 1'b0;
        end
        vectors++;
        if (bus.rsp_valid !== m_valid) begin
            miscompares++;
            $display("[TB] FAIL rsp_valid: got %b expected %b", bus.rsp_valid, m_valid);
        end
        if (m_valid) begin
            vectors++;
            if (bus.rsp_sum !== cur_sum || bus.rsp_id !== cur_id) begin
                miscompares++;
                $display("[TB] FAIL rsp_data: got sum=%h id=%0d expected sum=%h id=%0d",
                         bus.rsp_sum, bus.rsp_id, cur_sum, cur_id);
            end
        end
    endtask

    task automatic expect_rsp(input string name, input sum_t s, input req_id_t id);
        vectors++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== s || bus.rsp_id !== id) begin
            miscompares++;
            $display("[TB] FAIL %s: got v=%b sum=%h id=%0d expected v=1 sum=%h id=%0d",
                     name, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, s, id);
        end
    endtask

    task automatic test_reset();
        int a;
        rst_n = 1'b0;
        clear_reqs();
        bus.rsp_ready = 1'b1;
        model_reset();
        #3;
        vectors++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== '0 || bus.rsp_id !== '0 ||
            bus.req_ready !== '0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got v=%b sum=%h id=%0d rdy=%b busy=%b expected all 0",
                     bus.rsp_valid, bus.rsp_sum, bus.rsp_id, bus.req_ready, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle(a);
    endtask

    task automatic test_chain_single();
        int a;
        set_req(0, 1'b1, 15'h7FFF, 15'h0001, 1'b0);
        cycle(a);
        expect_rsp("carry_out", 16'h8000, 2'd0);
        set_req(0, 1'b1, 15'h0000, 15'h0000, 1'b1);
        cycle(a);
        expect_rsp("chain_cin", 16'h0001, 2'd0);
        clear_reqs();
        cycle(a);
    endtask

    task automatic test_round_robin();
        int a;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, operand_t'(i * 16'h1111), operand_t'(16'h0F0F + i), 1'b0);
        for (int k = 0; k < 2 * NREQ; k++) begin
            cycle(a);
            vectors++;
            if (a !== (1 + k) % NREQ) begin
                miscompares++;
                $display("[TB] FAIL rr_order: got %0d expected %0d", a, (1 + k) % NREQ);
            end
            if (a >= 0) set_req(a, 1'b1, operand_t'($urandom), operand_t'($urandom), 1'b0);
        end
    endtask

    task automatic test_back_to_back_backpressure();
        int a;
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) cycle(a);
        bus.rsp_ready = 1'b1;
        cycle(a);
        vectors++;
        if (a < 0) begin
            miscompares++;
            $display("[TB] FAIL no_bubble: got no accept expected an accept");
        end
        clear_reqs();
        cycle(a);
    endtask

    task automatic test_interleaved_chain();
        int a;
        clear_reqs();
        set_req(1, 1'b1, 15'h2000, 15'h2000, 1'b0);
        cycle(a);
        expect_rsp("il_req1_a", 16'h4000, 2'd1);
        clear_reqs();
        set_req(2, 1'b1, 15'h7FFF, 15'h7FFF, 1'b0);
        cycle(a);
        expect_rsp("il_req2_a", 16'hFFFE, 2'd2);
        clear_reqs();
        set_req(1, 1'b1, 15'h0000, 15'h0000, 1'b1);
        cycle(a);
        expect_rsp("il_req1_b", 16'h0000, 2'd1);
        clear_reqs();
        set_req(2, 1'b1, 15'h0000, 15'h0000, 1'b1);
        cycle(a);
        expect_rsp("il_req2_b", 16'h0001, 2'd2);
        clear_reqs();
        cycle(a);
    endtask

    // Random traffic; a requester keeps its operands until accepted.
    task automatic test_random();
        int a;
        clear_reqs();
        for (int k = 0; k < 60; k++) begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i]) begin
                    set_req(i, logic'($urandom_range(0, 1)), operand_t'($urandom),
                            operand_t'($urandom), logic'($urandom_range(0, 1)));
                end
            end
            cycle(a);
            if (a >= 0) bus.req_valid[a] = 1'b0;
        end
        clear_reqs();
        bus.rsp_ready = 1'b1;
        cycle(a);
    endtask

    task automatic test_reset_mid();
        int a;
        clear_reqs();
        bus.rsp_ready = 1'b1;
        set_req(1, 1'b1, 15'h7FFF, 15'h0001, 1'b0);
        cycle(a);
        clear_reqs();
        bus.rsp_ready = 1'b0;
        cycle(a);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== '0 || bus.rsp_id !== '0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got v=%b sum=%h id=%0d expected v=0 sum=0 id=0",
                     bus.rsp_valid, bus.rsp_sum, bus.rsp_id);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        cycle(a);
        set_req(1, 1'b1, 15'h0000, 15'h0000, 1'b1);
        set_req(3, 1'b1, 15'h0000, 15'h0000, 1'b1);
        cycle(a);
        expect_rsp("post_reset", 16'h0000, 2'd1);
        clear_reqs();
        cycle(a);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_chain_single();
        test_round_robin();
        test_back_to_back_backpressure();
        test_interleaved_chain();
        test_random();
        test_reset_mid();
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
